cla_adder4: RTL and testbench

4-bit carry-lookahead adder slice with a registered sum and a one-cycle ready handshake. Four instances are chained through `c_in`/`c_out` to form the 16-bit add/subtract unit of the 8-bit FPGA computer datapath. The carry path is purely combinational, so a chain settles within one clock. Sum and ready are registered.

---
 rtl/cla_adder4_if.sv | 28 ++
 rtl/cla_adder4.sv | 71 +++++++
 tb/tb_cla_adder4.sv | 138 +++++++++++++
 3 files changed

// File: rtl/cla_adder4_if.sv
// cla_adder4_if: operand/result bundle for one 4-bit carry-lookahead slice.
//   master : drives en, c_in, A, B; observes Output, c_out, ready
//            (and grp_p, grp_g when the group terms are built in).
//   slave  : the adder slice side of the same signals.
// Optional: CLA_ADDER_GROUP_PG_EN adds grp_p/grp_g group propagate/generate.
interface cla_adder4_if;
  logic       en;
  logic       c_in;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] Output;
  logic       c_out;
  logic       ready;
`ifdef CLA_ADDER_GROUP_PG_EN
  logic       grp_p;
  logic       grp_g;

  modport master (output en, c_in, A, B,
                  input  Output, c_out, ready, grp_p, grp_g);
  modport slave  (input  en, c_in, A, B,
                  output Output, c_out, ready, grp_p, grp_g);
`else
  modport master (output en, c_in, A, B,
                  input  Output, c_out, ready);
  modport slave  (input  en, c_in, A, B,
                  output Output, c_out, ready);
`endif
endinterface

// File: rtl/cla_adder4.sv
// cla_adder4: 4-bit carry-lookahead adder slice with a registered sum and
// a ready flag. Slices chain through c_in/c_out; the carry path is pure
// two-level logic so a 4-slice chain settles inside one clock period.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high; clears Output and ready
//   bus    : cla_adder4_if.slave
//            en      - capture sum (and raise ready) on each edge while high
//            c_in    - carry into bit 0
//            A, B    - addends (B pre-inverted by the parent for subtract)
//            Output  - registered sum, zero while en is low
//            c_out   - combinational carry out of bit 3
//            ready   - registered, high when Output holds a valid sum
//            grp_p/grp_g - group propagate/generate (CLA_ADDER_GROUP_PG_EN)
// Optional feature macro: CLA_ADDER_GROUP_PG_EN.
module cla_adder4 (
  input logic         clk,
  input logic         reset,
  cla_adder4_if.slave bus
);

  logic [3:0] g_s;
  logic [3:0] p_s;
  logic [4:0] c_s;
  logic [3:0] sum_s;
  logic [3:0] out_r;
  logic       ready_r;

  // Bitwise generate/propagate, flattened lookahead carries and sum bits.
  always_comb begin
    g_s   = bus.A & bus.B;
    p_s   = bus.A ^ bus.B;
    c_s   = 5'b0_0000;
    c_s[0] = bus.c_in;
    // Every carry is a single sum-of-products of c_in, g and p: no ripple.
    c_s[1] = g_s[0] | (p_s[0] & bus.c_in);
    c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & bus.c_in);
    c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
           | (p_s[2] & p_s[1] & p_s[0] & bus.c_in);
    c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
           | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
           | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & bus.c_in);
    sum_s = p_s ^ c_s[3:0];
  end

  // Sum and ready registers; dropping en clears both so stale sums never look valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_r   <= 4'h0;
      ready_r <= 1'b0;
    end else if (bus.en) begin
      out_r   <= sum_s;
      ready_r <= 1'b1;
    end else begin
      out_r   <= 4'h0;
      ready_r <= 1'b0;
    end
  end

  assign bus.Output = out_r;
  assign bus.ready  = ready_r;
  assign bus.c_out  = c_s[4];

`ifdef CLA_ADDER_GROUP_PG_EN
  // Group terms exclude c_in so a second-level lookahead unit can use them.
  assign bus.grp_p = p_s[3] & p_s[2] & p_s[1] & p_s[0];
  assign bus.grp_g = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                   | (p_s[3] & p_s[2] & p_s[1] & g_s[0]);
`endif

endmodule

// File: tb/tb_cla_adder4.sv
// tb_cla_adder4: self-checking bench for cla_adder4. One slice is driven with
// directed, exhaustive and random operands against an arithmetic model
// (A + B + c_in); four more slices form a chained 16-bit adder.
module tb_cla_adder4;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  cla_adder4_if dif ();
  cla_adder4_if cif0 ();
  cla_adder4_if cif1 ();
  cla_adder4_if cif2 ();
  cla_adder4_if cif3 ();

  cla_adder4 u_dut (.clk(clk), .reset(reset), .bus(dif));
  cla_adder4 u_s0  (.clk(clk), .reset(reset), .bus(cif0));
  cla_adder4 u_s1  (.clk(clk), .reset(reset), .bus(cif1));
  cla_adder4 u_s2  (.clk(clk), .reset(reset), .bus(cif2));
  cla_adder4 u_s3  (.clk(clk), .reset(reset), .bus(cif3));

  assign cif1.c_in = cif0.c_out;
  assign cif2.c_in = cif1.c_out;
  assign cif3.c_in = cif2.c_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply operands at the falling edge, check carry (and group terms), then
  // check the registered result just after the next rising edge.
  task automatic step(input logic e, input logic [3:0] a, input logic [3:0] b, input logic ci);
    logic [4:0] total;
    @(negedge clk);
    dif.en = e; dif.A = a; dif.B = b; dif.c_in = ci;
    total = 5'(a) + 5'(b) + 5'(ci);
    #1;
    check("c_out", 32'(dif.c_out), 32'(total[4]));
`ifdef CLA_ADDER_GROUP_PG_EN
    check("grp_p", 32'(dif.grp_p), 32'((5'(a) + 5'(b)) == 5'd15));
    check("grp_g", 32'(dif.grp_g), 32'((5'(a) + 5'(b)) >= 5'd16));
`endif
    @(posedge clk);
    #1;
    check("output", 32'(dif.Output), e ? 32'(total[3:0]) : 32'd0);
    check("ready", 32'(dif.ready), 32'(e));
  endtask

  initial begin
    logic [15:0] ca;
    logic [15:0] cb;
    logic [16:0] ctot;
    checks = 0;
    errors = 0;
    cif0.en = 1'b0; cif0.A = 4'h0; cif0.B = 4'h0; cif0.c_in = 1'b0;
    cif1.en = 1'b0; cif1.A = 4'h0; cif1.B = 4'h0;
    cif2.en = 1'b0; cif2.A = 4'h0; cif2.B = 4'h0;
    cif3.en = 1'b0; cif3.A = 4'h0; cif3.B = 4'h0;

    // Reset with en high: registers clear at once, carry still live.
    reset = 1'b1;
    dif.en = 1'b1; dif.A = 4'hF; dif.B = 4'h1; dif.c_in = 1'b0;
    #2;
    check("rst_output", 32'(dif.Output), 32'd0);
    check("rst_ready", 32'(dif.ready), 32'd0);
    check("rst_c_out", 32'(dif.c_out), 32'd1);
    @(posedge clk); #1;
    check("rst_wins_ready", 32'(dif.ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rel_output", 32'(dif.Output), 32'd0);
    check("rel_ready", 32'(dif.ready), 32'd1);
    check("rel_c_out", 32'(dif.c_out), 32'd1);

    // Basic add, full carry chain, enable drop.
    step(1'b1, 4'd3, 4'd4, 1'b0);
    step(1'b1, 4'hF, 4'h0, 1'b1);
    step(1'b1, 4'd5, 4'd6, 1'b0);
    step(1'b0, 4'd5, 4'd6, 1'b0);

    // Mid-operation reset: clears immediately, then first enabled edge recovers.
    step(1'b1, 4'd3, 4'd4, 1'b0);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    check("mid_rst_output", 32'(dif.Output), 32'd0);
    check("mid_rst_ready", 32'(dif.ready), 32'd0);
    check("mid_rst_c_out", 32'(dif.c_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 4'd9, 4'd9, 1'b0);

    // Exhaustive sweep with en held high.
    for (int ci = 0; ci < 2; ci++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          step(1'b1, 4'(a), 4'(b), 1'(ci));

    // Random operands and enable.
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom), 1'($urandom));

    // Chained 16-bit adder: directed case then a few random ones.
    for (int k = 0; k < 6; k++) begin
      if (k == 0) begin
        ca = 16'h00FF; cb = 16'h0001;
      end else begin
        ca = 16'($urandom); cb = 16'($urandom);
      end
      ctot = 17'(ca) + 17'(cb);
      @(negedge clk);
      cif0.A = ca[3:0];   cif0.B = cb[3:0];
      cif1.A = ca[7:4];   cif1.B = cb[7:4];
      cif2.A = ca[11:8];  cif2.B = cb[11:8];
      cif3.A = ca[15:12]; cif3.B = cb[15:12];
      cif0.c_in = 1'b0;
      cif0.en = 1'b1; cif1.en = 1'b1; cif2.en = 1'b1; cif3.en = 1'b1;
      #1;
      check("chain_c_out", 32'(cif3.c_out), 32'(ctot[16]));
      @(posedge clk); #1;
      check("chain_sum", 32'({cif3.Output, cif2.Output, cif1.Output, cif0.Output}), 32'(ctot[15:0]));
      check("chain_ready", 32'({cif3.ready, cif2.ready, cif1.ready, cif0.ready}), 32'd15);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
